byte_to_pixel_unpacker: RTL and testbench
=========================================

# byte_to_pixel_unpacker

Converts the received Ethernet payload byte stream (one byte per `dclk` while `en` is high) into per-channel VRAM writes. It sits between the RX MAC payload output and the per-channel frame-buffer RAMs, as the parametrised successor of the fixed 8-to-24-bit RGB converter. It searches for a 32-bit header, captures a start pixel address and unpacks `CH` bytes per pixel into `CH` write strobes. Additions: arbitrary channel count, configurable header/address format, address range checking, a per-packet pixel limit, and status pulses.

## Interface
- `CH`, 3, bytes (channels) per pixel; 1..8
- `ADDR_W`, 16, VRAM address width
- `MAX_ADDR`, 57600, number of valid pixel addresses (0..MAX_ADDR-1); ≤ 2**ADDR_W
- `HDR`, 32'h05A80000, header pattern, most significant byte first on the wire
- `ADDR_BYTES`, 3, address bytes following the header, big-endian; 1..4
- `PIX_LIMIT`, 0, max pixels per packet; 0 = unlimited
- `dclk` in 1 — sole clock
- `rst_n` in 1 — synchronous, active-low reset
- `en` in 1 — payload byte valid; low = packet gap
- `data8b` in 8 — payload byte
- `addr2vram` out ADDR_W — pixel address of the current write
- `data_rgb` out 8 — byte being written
- `we` out CH — one-hot channel write strobe; `we[i]` = channel i
- `pix_done` out 1 — pulse with the write of channel CH-1
- `pkt_err` out 1 — 1-cycle pulse: start address ≥ MAX_ADDR
- `pkt_end` out 1 — 1-cycle pulse: DATA state left (en low or limit hit)
- `pix_count` out 16 — pixels completed in the current/last packet, saturating

## Operation
- Input stage: `data8b`/`en` are registered once (`d_r`, `en_r`). All logic acts on the registered values.
- Header window: a 32-bit shift register takes `d_r` each cycle `en_r`=1 and is cleared when `en_r`=0. A match is `window == HDR`, evaluated only in IDLE.
- States:
  - IDLE: `we`=0. On match → ADDR with byte index 0. The byte that completes the match is the last header byte, not an address byte.
  - ADDR: shift `d_r` into the assembled address. After ADDR_BYTES bytes, the address is the full value, not truncated:
    - If < MAX_ADDR: `ptr` = address[ADDR_W-1:0], `ch`=0, `pix_count`=0 → DATA.
    - Else: pulse `pkt_err` → DROP.
  - DATA: each `en_r` byte drives `data_rgb`=`d_r`, `we`=1<<ch, `addr2vram`=ptr.
    - If ch==CH-1: pulse `pix_done`; ch←0; ptr←(ptr==MAX_ADDR-1)?0:ptr+1; `pix_count`+1, saturating at 16'hFFFF.
    - Otherwise ch+1.
    - If PIX_LIMIT≠0 and the completed pixel count reaches PIX_LIMIT → DROP with a `pkt_end` pulse.
    - Header patterns inside DATA are payload and are ignored.
  - DROP: `we`=0; stays until `en_r`=0 → IDLE.
- `en_r`=0 in any state → IDLE and `we`=0; `ch` cleared. The next cycle `ptr` and the partial address are don't-care.
  - `pkt_end` pulses if the state was DATA.
  - A partial pixel (ch≠0) at packet end is abandoned; channels already written stay written.
- A first data byte directly follows the last address byte (no gap cycle).

## Timing
- Latency: a byte on `data8b` at edge N produces `we`/`data_rgb`/`addr2vram` registered at edge N+2, valid during cycle N+2..N+3.
- `pix_done`, `pkt_err` and `pkt_end` are registered and aligned with the `we` cycle of the byte that caused them.
  - `pkt_end` on `en` fall is asserted 2 edges after `en` is first sampled low.
- Reset (rst_n=0 at an edge): state=IDLE, window=0, `addr2vram`=0, `data_rgb`=0, `we`=0, `pix_done`=`pkt_err`=`pkt_end`=0, `pix_count`=0, ch=0. Reset mid-packet discards the packet; no `pkt_end` pulse.
- Reset has priority over `en`.
- Address wrap at MAX_ADDR-1 → 0 occurs on the same edge as the CH-1 write; the next pixel's first write uses address 0.

## Structure
- Shared package `rx_pkt_pkg`: state enum (IDLE, ADDR, DATA, DROP), default HDR constant, default MAX_ADDR constant.
- One natural sub-module, `hdr_matcher`: the 32-bit window plus compare, with clear-on-gap. Everything else sits in the top.

## Test plan
- Defaults; stream 05 A8 00 00 00 12 34 then 6 bytes AA..FF with `en` high → writes at 0x1234 (we 001,010,100) then 0x1235; `pix_done` twice; `pix_count`=2.
- Start address 0x00E0FF (57599) with 2 pixels → second pixel written at address 0; `pkt_end` when `en` drops.
- Start address 0x00E100 (57600) → `pkt_err` pulse; no `we`; block ignores bytes until `en` low.
- `en` dropped after 4 data bytes (1⅓ pixels) → `pkt_end`; next packet restarts at ch 0 with its own address.
- CH=4, PIX_LIMIT=2, 12 data bytes → exactly 8 `we` pulses, `pkt_end` at the 8th, remaining bytes dropped.
- Header bytes 05 A8 00 00 split by an `en` low gap → no detection; `rst_n` low mid-DATA → all outputs 0 next cycle.

Source files
------------

// File: rtl/rx_pkt_pkg.sv
// Shared types and defaults for the RX payload unpacking path.
package rx_pkt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } rx_state_e;

   localparam logic [31:0]  DEF_HDR      = 32'h05A8_0000;
   localparam int unsigned  DEF_MAX_ADDR = 57600;
   localparam int unsigned  PIX_CNT_W    = 16;

endpackage

// File: rtl/hdr_matcher.sv
// 32-bit sliding header window over the registered byte stream, cleared on gaps.
module hdr_matcher
   import rx_pkt_pkg::*;
#(
   parameter logic [31:0] HDR = DEF_HDR
) (
   input  logic       dclk,
   input  logic       rst_n,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       match_c
);

   logic [31:0] window;

   always_ff @(posedge dclk) begin
      if (!rst_n)     window <= '0;
      else if (valid) window <= {window[23:0], data};
      else            window <= '0;
   end

   // Look at the value the window takes on this edge so the byte after the
   // last header byte is seen as the first address byte.
   assign match_c = valid && ({window[23:0], data} == HDR);

endmodule

// File: rtl/byte_to_pixel_unpacker.sv
// Unpacks a headered payload byte stream into per-channel VRAM write strobes.
module byte_to_pixel_unpacker
   import rx_pkt_pkg::*;
#(
   parameter int unsigned CH         = 3,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned MAX_ADDR   = DEF_MAX_ADDR,
   parameter logic [31:0] HDR        = DEF_HDR,
   parameter int unsigned ADDR_BYTES = 3,
   parameter int unsigned PIX_LIMIT  = 0
) (
   input  logic              dclk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [7:0]        data8b,
   output logic [ADDR_W-1:0] addr2vram,
   output logic [7:0]        data_rgb,
   output logic [CH-1:0]     we,
   output logic              pix_done,
   output logic              pkt_err,
   output logic              pkt_end,
   output logic [15:0]       pix_count
);

   localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;
   localparam int unsigned IDX_W = 2;

   logic                 en_r;
   logic [7:0]           d_r;
   logic                 match_c;

   rx_state_e            state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [31:0]          addr_q, addr_d;
   logic [ADDR_W-1:0]    ptr_q, ptr_d;
   logic [CH_W-1:0]      ch_q, ch_d;

   logic [ADDR_W-1:0]    addr2vram_d;
   logic [7:0]           data_rgb_d;
   logic [CH-1:0]        we_d;
   logic                 pix_done_d, pkt_err_d, pkt_end_d;
   logic [15:0]          pix_count_d;

   logic [31:0]          addr_full;
   logic [15:0]          pix_inc;

   hdr_matcher #(.HDR(HDR)) u_hdr (
      .dclk    (dclk),
      .rst_n   (rst_n),
      .valid   (en_r),
      .data    (d_r),
      .match_c (match_c)
   );

   assign addr_full = {addr_q[23:0], d_r};
   assign pix_inc   = (pix_count == 16'hFFFF) ? pix_count : pix_count + 16'd1;

   // Next-state and next-output decode.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      ptr_d       = ptr_q;
      ch_d        = ch_q;
      addr2vram_d = addr2vram;
      data_rgb_d  = data_rgb;
      we_d        = '0;
      pix_done_d  = 1'b0;
      pkt_err_d   = 1'b0;
      pkt_end_d   = 1'b0;
      pix_count_d = pix_count;

      if (!en_r) begin
         state_d = IDLE;
         ch_d    = '0;
         if (state_q == DATA) pkt_end_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (match_c) begin
                  state_d = ADDR;
                  idx_d   = '0;
                  addr_d  = '0;
               end
            end
            ADDR: begin
               addr_d = addr_full;
               if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
                  if ({1'b0, addr_full} < 33'(MAX_ADDR)) begin
                     ptr_d       = ADDR_W'(addr_full);
                     ch_d        = '0;
                     pix_count_d = '0;
                     state_d     = DATA;
                  end else begin
                     pkt_err_d = 1'b1;
                     state_d   = DROP;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            DATA: begin
               data_rgb_d  = d_r;
               we_d        = CH'(1) << ch_q;
               addr2vram_d = ptr_q;
               if (ch_q == CH_W'(CH - 1)) begin
                  pix_done_d  = 1'b1;
                  ch_d        = '0;
                  ptr_d       = (ptr_q == ADDR_W'(MAX_ADDR - 1)) ? '0 : ptr_q + ADDR_W'(1);
                  pix_count_d = pix_inc;
                  if ((PIX_LIMIT != 0) && (32'(pix_inc) == PIX_LIMIT)) begin
                     state_d   = DROP;
                     pkt_end_d = 1'b1;
                  end
               end else begin
                  ch_d = ch_q + CH_W'(1);
               end
            end
            DROP:    state_d = DROP;
            default: state_d = IDLE;
         endcase
      end
   end

   // Input stage, state and registered outputs.
   always_ff @(posedge dclk) begin
      if (!rst_n) begin
         en_r      <= 1'b0;
         d_r       <= '0;
         state_q   <= IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         ptr_q     <= '0;
         ch_q      <= '0;
         addr2vram <= '0;
         data_rgb  <= '0;
         we        <= '0;
         pix_done  <= 1'b0;
         pkt_err   <= 1'b0;
         pkt_end   <= 1'b0;
         pix_count <= '0;
      end else begin
         en_r      <= en;
         d_r       <= data8b;
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         ptr_q     <= ptr_d;
         ch_q      <= ch_d;
         addr2vram <= addr2vram_d;
         data_rgb  <= data_rgb_d;
         we        <= we_d;
         pix_done  <= pix_done_d;
         pkt_err   <= pkt_err_d;
         pkt_end   <= pkt_end_d;
         pix_count <= pix_count_d;
      end
   end

endmodule

// File: tb/tb_byte_to_pixel_unpacker.sv
// Bench: directed + random packets into a 3-channel and a 4-channel/2-pixel-limit unpacker.
module tb_byte_to_pixel_unpacker;

   localparam int          N     = 1500;
   localparam logic [31:0] HDR_C = 32'h05A8_0000;
   localparam longint      MAXA  = 57600;
   localparam int          AB    = 3;

   logic        dclk;
   logic        rst_n;
   logic        en;
   logic [7:0]  data8b;

   logic [15:0] a0, a1, pc0, pc1;
   logic [7:0]  d0, d1;
   logic [2:0]  we0;
   logic [3:0]  we1;
   logic        pd0, pd1, er0, er1, pe0, pe1;

   byte_to_pixel_unpacker u_def (
      .dclk(dclk), .rst_n(rst_n), .en(en), .data8b(data8b),
      .addr2vram(a0), .data_rgb(d0), .we(we0), .pix_done(pd0),
      .pkt_err(er0), .pkt_end(pe0), .pix_count(pc0)
   );

   byte_to_pixel_unpacker #(.CH(4), .PIX_LIMIT(2)) u_lim (
      .dclk(dclk), .rst_n(rst_n), .en(en), .data8b(data8b),
      .addr2vram(a1), .data_rgb(d1), .we(we1), .pix_done(pd1),
      .pkt_err(er1), .pkt_end(pe1), .pix_count(pc1)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   int n_vec = 0;
   int n_err = 0;

   // Stimulus, one entry per input cycle.
   logic       en_s [N];
   logic [7:0] d_s  [N];
   int         ns = 0;

   // Expected outputs per instance, indexed by the input cycle that caused them.
   logic [7:0] x_we   [2][N];
   int         x_addr [2][N];
   logic [7:0] x_dat  [2][N];
   logic       x_pd   [2][N];
   logic       x_err  [2][N];
   logic       x_end  [2][N];
   int         x_pc   [2][N];
   int         pc_run [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic string tg(input string nm, input int k, input int idx);
      return $sformatf("%s[%0d]@%0d", nm, k, idx);
   endfunction

   task automatic put(input logic e, input logic [7:0] b);
      if (ns < N) begin
         en_s[ns] = e;
         d_s[ns]  = b;
         ns++;
      end
   endtask

   task automatic gap(input int n);
      repeat (n) put(1'b0, 8'($urandom));
   endtask

   task automatic hdr();
      put(1'b1, 8'h05); put(1'b1, 8'hA8); put(1'b1, 8'h00); put(1'b1, 8'h00);
   endtask

   task automatic addr3(input int a);
      put(1'b1, 8'(a >> 16)); put(1'b1, 8'(a >> 8)); put(1'b1, 8'(a));
   endtask

   task automatic payload(input int n);
      repeat (n) put(1'b1, 8'($urandom));
   endtask

   // Packet-level reference: find header per en-high run, then place each data byte arithmetically.
   task automatic model(input int k, input int chn, input int lim);
      int s, e, len, p, ca, j, cyc;
      longint a;
      logic hit;
      for (int i = 0; i < N; i++) begin
         x_we[k][i] = '0; x_addr[k][i] = 0; x_dat[k][i] = '0;
         x_pd[k][i] = 1'b0; x_err[k][i] = 1'b0; x_end[k][i] = 1'b0; x_pc[k][i] = -1;
      end
      s = 0;
      while (s < ns) begin
         if (!en_s[s]) begin
            s++;
         end else begin
            e = s;
            while (e + 1 < ns && en_s[e+1]) e++;
            len = e - s + 1;
            p = -1;
            for (int q = 3; q < len && p < 0; q++)
               if ({d_s[s+q-3], d_s[s+q-2], d_s[s+q-1], d_s[s+q]} == HDR_C) p = q;
            if (p >= 0 && p + AB < len) begin
               a = 0;
               for (int q = 1; q <= AB; q++) a = a * 256 + longint'(d_s[s+p+q]);
               ca = s + p + AB;
               if (a >= MAXA) begin
                  x_err[k][ca] = 1'b1;
               end else begin
                  x_pc[k][ca] = 0;
                  hit = 1'b0;
                  for (int q = p + AB + 1; q < len && !hit; q++) begin
                     j   = q - p - AB - 1;
                     cyc = s + q;
                     x_we[k][cyc]   = 8'(1 << (j % chn));
                     x_addr[k][cyc] = int'((a + longint'(j / chn)) % MAXA);
                     x_dat[k][cyc]  = d_s[cyc];
                     if (j % chn == chn - 1) begin
                        x_pd[k][cyc] = 1'b1;
                        x_pc[k][cyc] = j / chn + 1;
                        if (lim != 0 && j / chn + 1 == lim) begin
                           x_end[k][cyc] = 1'b1;
                           hit = 1'b1;
                        end
                     end
                  end
                  if (!hit && e + 1 < N) x_end[k][e+1] = 1'b1;
               end
            end
            s = e + 1;
         end
      end
   endtask

   task automatic check_inst(input int k, input int idx, input logic [7:0] we_o,
                             input logic [15:0] a_o, input logic [7:0] d_o,
                             input logic pd_o, input logic er_o, input logic pe_o,
                             input logic [15:0] pc_o);
      if (x_pc[k][idx] >= 0) pc_run[k] = x_pc[k][idx];
      chk(tg("we", k, idx), 64'(we_o), 64'(x_we[k][idx]));
      if (x_we[k][idx] != 8'h00) begin
         chk(tg("addr", k, idx), 64'(a_o), 64'(x_addr[k][idx]));
         chk(tg("data", k, idx), 64'(d_o), 64'(x_dat[k][idx]));
      end
      chk(tg("pix_done", k, idx), 64'(pd_o), 64'(x_pd[k][idx]));
      chk(tg("pkt_err",  k, idx), 64'(er_o), 64'(x_err[k][idx]));
      chk(tg("pkt_end",  k, idx), 64'(pe_o), 64'(x_end[k][idx]));
      chk(tg("pix_count", k, idx), 64'(pc_o), 64'(pc_run[k]));
   endtask

   task automatic tick(input logic r, input logic e, input logic [7:0] b);
      @(posedge dclk);
      #1;
      rst_n  = r;
      en     = e;
      data8b = b;
      @(negedge dclk);
   endtask

   initial begin
      int sel, a;
      rst_n = 1'b0; en = 1'b0; data8b = '0;
      pc_run[0] = 0; pc_run[1] = 0;

      // Directed packets.
      gap(3);
      hdr(); addr3(32'h1234);
      put(1'b1, 8'hAA); put(1'b1, 8'hBB); put(1'b1, 8'hCC);
      put(1'b1, 8'hDD); put(1'b1, 8'hEE); put(1'b1, 8'hFF);
      gap(3);
      hdr(); addr3(57599); payload(6); gap(2);
      hdr(); addr3(57600); payload(5); gap(2);
      hdr(); addr3(32'h10); payload(4); gap(2);
      hdr(); addr3(32'h20); payload(3); gap(2);
      hdr(); addr3(32'h30); payload(12); gap(2);
      put(1'b1, 8'h05); put(1'b1, 8'hA8); gap(1);
      put(1'b1, 8'h00); put(1'b1, 8'h00); put(1'b1, 8'h00); put(1'b1, 8'h00);
      put(1'b1, 8'h01); payload(3); gap(2);
      hdr(); addr3(32'h40);
      put(1'b1, 8'h05); put(1'b1, 8'hA8); put(1'b1, 8'h00); put(1'b1, 8'h00);
      payload(5); gap(2);

      // Random packets.
      while (ns < N - 40) begin
         repeat ($urandom_range(0, 2)) put(1'b1, 8'($urandom_range(0, 7)));
         if ($urandom_range(0, 9) != 0) hdr();
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       a = 57598 + int'($urandom_range(0, 3));
            1:       a = int'($urandom_range(0, 57599));
            2:       a = int'($urandom_range(0, 32'hFF_FFFF));
            default: a = 57599;
         endcase
         if ($urandom_range(0, 9) == 0) begin
            put(1'b1, 8'(a >> 16));
         end else begin
            addr3(a);
            payload(int'($urandom_range(0, 14)));
         end
         gap(int'($urandom_range(1, 3)));
      end
      gap(4);

      model(0, 3, 0);
      model(1, 4, 2);

      // Reset state.
      repeat (3) tick(1'b0, 1'b0, 8'h00);
      chk("rst_we0",  64'(we0), 64'd0);
      chk("rst_we1",  64'(we1), 64'd0);
      chk("rst_addr", 64'(a0),  64'd0);
      chk("rst_data", 64'(d0),  64'd0);
      chk("rst_pc",   64'(pc0), 64'd0);
      chk("rst_flags", 64'({pd0, er0, pe0, pd1, er1, pe1}), 64'd0);

      // Main run against the model (two-cycle latency).
      for (int i = 0; i < ns + 2; i++) begin
         if (i < ns) tick(1'b1, en_s[i], d_s[i]);
         else        tick(1'b1, 1'b0, 8'h00);
         if (i >= 2) begin
            check_inst(0, i - 2, 8'(we0), a0, d0, pd0, er0, pe0, pc0);
            check_inst(1, i - 2, 8'(we1), a1, d1, pd1, er1, pe1, pc1);
         end
      end

      // Reset in the middle of DATA: everything clears, no pkt_end afterwards.
      repeat (2) tick(1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b1, 8'h05); tick(1'b1, 1'b1, 8'hA8);
      tick(1'b1, 1'b1, 8'h00); tick(1'b1, 1'b1, 8'h00);
      tick(1'b1, 1'b1, 8'h00); tick(1'b1, 1'b1, 8'h01); tick(1'b1, 1'b1, 8'h00);
      tick(1'b1, 1'b1, 8'h11); tick(1'b1, 1'b1, 8'h22);
      tick(1'b1, 1'b1, 8'h33); tick(1'b1, 1'b1, 8'h44);
      tick(1'b0, 1'b1, 8'h55);
      chk("mid_we",   64'(we0), 64'd4);
      chk("mid_addr", 64'(a0),  64'h100);
      chk("mid_data", 64'(d0),  64'h33);
      tick(1'b0, 1'b0, 8'h00);
      chk("rstd_we",   64'({we0, we1}), 64'd0);
      chk("rstd_addr", 64'(a0), 64'd0);
      chk("rstd_data", 64'(d0), 64'd0);
      chk("rstd_pc",   64'(pc0), 64'd0);
      chk("rstd_flags", 64'({pd0, er0, pe0}), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, 8'h00);
         chk($sformatf("post_rst_end@%0d", i), 64'({pe0, pe1}), 64'd0);
         chk($sformatf("post_rst_we@%0d", i), 64'({we0, we1}), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
